// File: rtl/spi_pkg.sv
// Shared definitions for the CPHA=0 SPI master: FSM state encoding and
// the default SPI half-period length in system clock cycles.
package spi_pkg;

  // Default SPI half-period, in clk cycles (legal range 2..255).
  localparam int HALF_DIV_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for the SPI master. Counts 0..HALF_DIV-1 while enabled
// and flags the last count, which is where every FSM phase change happens.
// When disabled the count is parked at 0 so each transfer starts aligned.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LastCount = 8'(HALF_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: wrap on the last count, park at zero whenever disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == LastCount)) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LastCount);

endmodule

// File: rtl/spi_master_cpha0.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Every phase lasts one half-period. The first bit is presented as ssel
// falls, miso is sampled on each sck rise and mosi advances on each sck
// fall. TRAIL lasts two half-periods (the last sck low phase plus one
// half-period of ssel hold), so ssel stays low for 18*HALF_DIV cycles.
module spi_master_cpha0
  import spi_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ssel
);

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sck_q, sck_d;
  logic       ssel_q, ssel_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       trail_half_q, trail_half_d;
  logic       tick;

  assign busy = (state_q != ST_IDLE);

  spi_tick_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .tick(tick)
  );

  // Next-state and registered-output logic; every change waits for a tick
  // except the start of a transfer, which is taken immediately from IDLE.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
    sck_d        = sck_q;
    ssel_d       = ssel_q;
    mosi_d       = mosi_q;
    trail_half_d = trail_half_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sck_d  = 1'b0;
        ssel_d = 1'b1;
        mosi_d = 1'b0;
        if (start) begin
          tx_sh_d      = tx_data;
          rx_sh_d      = 8'h00;
          ssel_d       = 1'b0;
          mosi_d       = tx_data[7];
          bit_cnt_d    = 3'd0;
          trail_half_d = 1'b0;
          state_d      = ST_LEAD;
        end
      end
      ST_LEAD, ST_LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_TRAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            mosi_d    = tx_sh_q[6];
            state_d   = ST_LOW;
          end
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          if (!trail_half_q) begin
            trail_half_d = 1'b1;
          end else begin
            trail_half_d = 1'b0;
            ssel_d       = 1'b1;
            mosi_d       = 1'b0;
            rx_data_d    = rx_sh_q;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      tx_sh_q      <= 8'h00;
      rx_sh_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      sck_q        <= 1'b0;
      ssel_q       <= 1'b1;
      mosi_q       <= 1'b0;
      done_q       <= 1'b0;
      trail_half_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      sck_q        <= sck_d;
      ssel_q       <= ssel_d;
      mosi_q       <= mosi_d;
      done_q       <= done_d;
      trail_half_q <= trail_half_d;
    end
  end

  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign ssel    = ssel_q;

endmodule

// File: tb/tb_spi_master_cpha0.sv
// Testbench for spi_master_cpha0. Two instances (HALF_DIV=4 and 2) share
// the stimulus; useTwo picks which one is observed. Expected values come
// from what an SPI mode-0 byte transfer must look like on the wires.
module tb_spi_master_cpha0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] txData;
  logic       loopMode;
  logic       misoConst;
  bit         useTwo;

  logic       busy4, done4, sck4, mosi4, ssel4;
  logic [7:0] rx4;
  logic       busy2, done2, sck2, mosi2, ssel2;
  logic [7:0] rx2;
  logic       miso4, miso2;

  logic       obsBusy, obsDone, obsSck, obsMosi, obsSsel;
  logic [7:0] obsRx;

  int total = 0;
  int bad   = 0;

  assign miso4 = loopMode ? mosi4 : misoConst;
  assign miso2 = loopMode ? mosi2 : misoConst;

  assign obsBusy = useTwo ? busy2 : busy4;
  assign obsDone = useTwo ? done2 : done4;
  assign obsSck  = useTwo ? sck2  : sck4;
  assign obsMosi = useTwo ? mosi2 : mosi4;
  assign obsSsel = useTwo ? ssel2 : ssel4;
  assign obsRx   = useTwo ? rx2   : rx4;

  spi_master_cpha0 #(.HALF_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .tx_data(txData),
    .busy(busy4), .done(done4), .rx_data(rx4), .sck(sck4),
    .mosi(mosi4), .miso(miso4), .ssel(ssel4)
  );

  spi_master_cpha0 #(.HALF_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .tx_data(txData),
    .busy(busy2), .done(done2), .rx_data(rx2), .sck(sck2),
    .mosi(mosi2), .miso(miso2), .ssel(ssel2)
  );

  always #5 clk = ~clk;

  // Runs one byte transfer starting at the current negedge and returns at
  // the negedge where done is seen (or when the cycle budget runs out).
  task automatic doTransfer(input logic [7:0] tx, input bit loopback, input logic misoLevel,
                            input int restartAt, output logic [7:0] bitsSeen, output int rises,
                            output int sselLow, output int minRun, output int maxRun,
                            output logic [7:0] rxSeen, output bit gotDone,
                            output logic sselAtDone, output logic firstSsel);
    int   half;
    int   highRun;
    int   lowRun;
    logic prevSck;
    half       = useTwo ? 2 : 4;
    loopMode   = loopback;
    misoConst  = misoLevel;
    start      = 1'b1;
    txData     = tx;
    bitsSeen   = 8'h00;
    rises      = 0;
    sselLow    = 0;
    minRun     = 1000;
    maxRun     = 0;
    rxSeen     = 8'h00;
    gotDone    = 1'b0;
    sselAtDone = 1'b0;
    firstSsel  = 1'b1;
    highRun    = 0;
    lowRun     = 0;
    prevSck    = 1'b0;
    for (int cyc = 1; cyc <= 40 * half + 40 && !gotDone; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        txData    = ~tx;
        firstSsel = obsSsel;
      end
      if (cyc == restartAt) begin
        start  = 1'b1;
        txData = 8'h3C;
      end else begin
        start = 1'b0;
      end
      if (obsSsel == 1'b0) sselLow++;
      if (obsSck && !prevSck) begin
        bitsSeen = {bitsSeen[6:0], obsMosi};
        rises++;
        if (lowRun < minRun) minRun = lowRun;
        if (lowRun > maxRun) maxRun = lowRun;
        lowRun = 0;
      end
      if (!obsSck && prevSck) begin
        if (highRun < minRun) minRun = highRun;
        if (highRun > maxRun) maxRun = highRun;
        highRun = 0;
      end
      if (obsSck) highRun++;
      else lowRun++;
      prevSck = obsSck;
      if (obsDone) begin
        gotDone    = 1'b1;
        rxSeen     = obsRx;
        sselAtDone = obsSsel;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (obsSsel !== 1'b1) begin bad++; $display("FAIL reset_ssel: got %b want 1", obsSsel); end
    total++; if (obsSck !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", obsSck); end
    total++; if (obsMosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", obsMosi); end
    total++; if (obsBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", obsBusy); end
    total++; if (obsDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", obsDone); end
    total++; if (obsRx !== 8'h00) begin bad++; $display("FAIL reset_rx: got %h want 00", obsRx); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback(input logic [7:0] tx, input bit two);
    logic [7:0] bitsSeen, rxSeen;
    int rises, sselLow, minRun, maxRun, half;
    bit gotDone;
    logic sselAtDone, firstSsel;
    useTwo = two;
    half   = two ? 2 : 4;
    @(negedge clk);
    doTransfer(tx, 1'b1, 1'b0, 0, bitsSeen, rises, sselLow, minRun, maxRun, rxSeen,
               gotDone, sselAtDone, firstSsel);
    total++; if (gotDone !== 1'b1) begin bad++; $display("FAIL loop_done(hd=%0d): got %b want 1", half, gotDone); end
    total++; if (bitsSeen !== tx) begin bad++; $display("FAIL loop_mosi_bits(hd=%0d): got %h want %h", half, bitsSeen, tx); end
    total++; if (rxSeen !== tx) begin bad++; $display("FAIL loop_rx(hd=%0d): got %h want %h", half, rxSeen, tx); end
    total++; if (rises != 8) begin bad++; $display("FAIL loop_rises(hd=%0d): got %0d want 8", half, rises); end
    total++; if (sselLow != 18 * half) begin bad++; $display("FAIL loop_ssel_low(hd=%0d): got %0d want %0d", half, sselLow, 18 * half); end
    total++; if (minRun != half || maxRun != half) begin bad++; $display("FAIL loop_sck_phase(hd=%0d): got %0d..%0d want %0d", half, minRun, maxRun, half); end
    total++; if (sselAtDone !== 1'b1 || obsBusy !== 1'b0) begin bad++; $display("FAIL loop_done_idle(hd=%0d): got ssel=%b busy=%b want 1 0", half, sselAtDone, obsBusy); end
    @(negedge clk);
    total++; if (obsDone !== 1'b0 || obsRx !== tx || obsMosi !== 1'b0) begin bad++; $display("FAIL loop_after_done(hd=%0d): got done=%b rx=%h mosi=%b want 0 %h 0", half, obsDone, obsRx, obsMosi, tx); end
    useTwo = 1'b0;
  endtask

  task automatic test_miso_high();
    logic [7:0] bitsSeen, rxSeen;
    int rises, sselLow, minRun, maxRun;
    bit gotDone;
    logic sselAtDone, firstSsel;
    @(negedge clk);
    doTransfer(8'h00, 1'b0, 1'b1, 0, bitsSeen, rises, sselLow, minRun, maxRun, rxSeen,
               gotDone, sselAtDone, firstSsel);
    total++; if (bitsSeen !== 8'h00) begin bad++; $display("FAIL misohigh_mosi: got %h want 00", bitsSeen); end
    total++; if (rxSeen !== 8'hFF || !gotDone) begin bad++; $display("FAIL misohigh_rx: got %h done=%b want FF", rxSeen, gotDone); end
    total++; if (rises != 8) begin bad++; $display("FAIL misohigh_rises: got %0d want 8", rises); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] tx, bitsSeen, rxSeen;
    int rises, sselLow, minRun, maxRun, extraDone;
    bit gotDone;
    logic sselAtDone, firstSsel;
    tx = 8'($urandom);
    @(negedge clk);
    doTransfer(tx, 1'b1, 1'b0, 10, bitsSeen, rises, sselLow, minRun, maxRun, rxSeen,
               gotDone, sselAtDone, firstSsel);
    total++; if (rxSeen !== tx || bitsSeen !== tx || !gotDone) begin bad++; $display("FAIL ignore_rx: got rx=%h bits=%h done=%b want %h", rxSeen, bitsSeen, gotDone, tx); end
    total++; if (sselLow != 72) begin bad++; $display("FAIL ignore_ssel_low: got %0d want 72", sselLow); end
    extraDone = 0;
    repeat (12) begin
      @(negedge clk);
      if (obsDone) extraDone++;
    end
    total++; if (extraDone != 0 || obsBusy !== 1'b0) begin bad++; $display("FAIL ignore_single_done: got extra=%0d busy=%b want 0 0", extraDone, obsBusy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tx1, bitsSeen, rxSeen;
    int rises, sselLow, minRun, maxRun;
    bit gotDone;
    logic sselAtDone, firstSsel;
    tx1 = 8'($urandom);
    @(negedge clk);
    doTransfer(tx1, 1'b1, 1'b0, 0, bitsSeen, rises, sselLow, minRun, maxRun, rxSeen,
               gotDone, sselAtDone, firstSsel);
    total++; if (rxSeen !== tx1 || sselAtDone !== 1'b1) begin bad++; $display("FAIL b2b_first: got rx=%h ssel=%b want %h 1", rxSeen, sselAtDone, tx1); end
    doTransfer(8'h81, 1'b1, 1'b0, 0, bitsSeen, rises, sselLow, minRun, maxRun, rxSeen,
               gotDone, sselAtDone, firstSsel);
    total++; if (firstSsel !== 1'b0) begin bad++; $display("FAIL b2b_gap: got ssel=%b one cycle after done want 0", firstSsel); end
    total++; if (rxSeen !== 8'h81 || bitsSeen !== 8'h81 || sselLow != 72) begin bad++; $display("FAIL b2b_second: got rx=%h bits=%h low=%0d want 81 81 72", rxSeen, bitsSeen, sselLow); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] bitsSeen, rxSeen;
    int rises, sselLow, minRun, maxRun, waited, doneSeen;
    bit gotDone;
    logic sselAtDone, firstSsel, prevSck;
    @(negedge clk);
    loopMode = 1'b1;
    start    = 1'b1;
    txData   = 8'($urandom);
    prevSck  = obsSck;
    rises    = 0;
    waited   = 0;
    doneSeen = 0;
    @(negedge clk);
    start = 1'b0;
    while (rises < 5 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (obsSck && !prevSck) rises++;
      prevSck = obsSck;
    end
    total++; if (rises != 5) begin bad++; $display("FAIL abort_reach_bit4: got %0d rises want 5", rises); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (obsSsel !== 1'b1 || obsSck !== 1'b0 || obsBusy !== 1'b0 || obsDone !== 1'b0) begin
      bad++; $display("FAIL abort_immediate: got ssel=%b sck=%b busy=%b done=%b want 1 0 0 0", obsSsel, obsSck, obsBusy, obsDone);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (obsDone) doneSeen++;
    end
    total++; if (doneSeen != 0 || obsRx !== 8'h00) begin bad++; $display("FAIL abort_no_done: got dones=%0d rx=%h want 0 00", doneSeen, obsRx); end
    doTransfer(8'h5A, 1'b1, 1'b0, 0, bitsSeen, rises, sselLow, minRun, maxRun, rxSeen,
               gotDone, sselAtDone, firstSsel);
    total++; if (rxSeen !== 8'h5A || bitsSeen !== 8'h5A || !gotDone) begin bad++; $display("FAIL abort_recover: got rx=%h bits=%h done=%b want 5A 5A", rxSeen, bitsSeen, gotDone); end
  endtask

  task automatic test_random();
    logic [7:0] tx, want, bitsSeen, rxSeen;
    int rises, sselLow, minRun, maxRun;
    bit gotDone, loop;
    logic misoLevel, sselAtDone, firstSsel;
    for (int n = 0; n < 6; n++) begin
      tx        = 8'($urandom);
      loop      = 1'($urandom);
      misoLevel = 1'($urandom);
      want      = loop ? tx : {8{misoLevel}};
      @(negedge clk);
      doTransfer(tx, loop, misoLevel, 0, bitsSeen, rises, sselLow, minRun, maxRun, rxSeen,
                 gotDone, sselAtDone, firstSsel);
      total++; if (rxSeen !== want || bitsSeen !== tx || !gotDone) begin
        bad++; $display("FAIL random_%0d: got rx=%h bits=%h done=%b want rx=%h bits=%h", n, rxSeen, bitsSeen, gotDone, want, tx);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    txData    = 8'h00;
    loopMode  = 1'b1;
    misoConst = 1'b0;
    useTwo    = 1'b0;
    test_reset();
    test_loopback(8'hA5, 1'b0);
    test_miso_high();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_loopback(8'hC3, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
